alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl_pkg.sv | 14 +
 rtl/alarm_ctrl_secs_add_wrap.sv | 26 ++
 rtl/alarm_ctrl.sv | 138 +++++++++++++
 tb/tb_alarm_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared types and constants for the alarm controller
package alarm_ctrl_pkg;

  localparam int SECS_W       = 17;
  localparam int SECS_PER_DAY = 86400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/alarm_ctrl_secs_add_wrap.sv
// rtl/alarm_ctrl_secs_add_wrap.sv - (a + b) mod 86400 for seconds-of-day values
module secs_add_wrap
  import alarm_ctrl_pkg::*;
(
  input  logic [SECS_W-1:0] a,
  input  logic [SECS_W-1:0] b,
  output logic [SECS_W-1:0] sum
);

  localparam logic [SECS_W:0] DAY_EXT = (SECS_W + 1)'(SECS_PER_DAY);

  logic [SECS_W:0] raw;
  logic [SECS_W:0] wrapped;

  // Both operands are below one day, so one conditional subtract is enough.
  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    wrapped = raw - DAY_EXT;
    if (raw >= DAY_EXT) begin
      sum = wrapped[SECS_W-1:0];
    end else begin
      sum = raw[SECS_W-1:0];
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller with ring timeout and limited snooze
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [SECS_W-1:0] now_secs,
  input  logic              set_valid,
  input  logic [SECS_W-1:0] set_secs,
  input  logic              arm_toggle,
  input  logic              snooze,
  input  logic              dismiss,
  output logic [SECS_W-1:0] alarm_secs,
  output logic              armed,
  output logic              ringing,
  output logic              buzz,
  output logic [1:0]        snooze_left,
  output logic              set_err
);

  localparam int              RC_W      = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);
  localparam logic [1:0]      SNZ_FULL  = 2'(MAX_SNOOZE);
  localparam logic [SECS_W-1:0] DAY     = SECS_W'(SECS_PER_DAY);

  alarm_state_t      state, state_n;
  logic [RC_W-1:0]   ring_cnt, ring_cnt_n;
  logic              beep, beep_n;
  logic [SECS_W-1:0] wake, wake_n, wake_sum;
  logic [1:0]        left_n;
  logic [SECS_W-1:0] alarm_n;
  logic              set_bad;

  secs_add_wrap u_wake_add (
    .a   (now_secs),
    .b   (SECS_W'(SNOOZE_SECS)),
    .sum (wake_sum)
  );

  assign set_bad = set_valid && (set_secs >= DAY);

  // Next-state logic; priority is arm_toggle, dismiss, snooze, then tick events.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    beep_n     = beep;
    wake_n     = wake;
    left_n     = snooze_left;
    alarm_n    = alarm_secs;

    if (set_valid && !set_bad && (state == ST_IDLE || state == ST_ARMED)) begin
      alarm_n = set_secs;
    end

    case (state)
      ST_IDLE: begin
        if (arm_toggle) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (arm_toggle) begin
          state_n = ST_IDLE;
        end else if (tick && now_secs == alarm_secs) begin
          state_n    = ST_RINGING;
          ring_cnt_n = '0;
          beep_n     = 1'b1;
        end
      end
      ST_RINGING: begin
        if (arm_toggle) begin
          state_n = ST_IDLE;
          left_n  = SNZ_FULL;
        end else if (dismiss) begin
          state_n = ST_ARMED;
          left_n  = SNZ_FULL;
        end else if (snooze && snooze_left != 2'd0) begin
          state_n = ST_SNOOZED;
          wake_n  = wake_sum;
          left_n  = snooze_left - 2'd1;
        end else if (tick) begin
          if (ring_cnt == RING_LAST) begin
            state_n = ST_ARMED;
            left_n  = SNZ_FULL;
          end else begin
            ring_cnt_n = ring_cnt + RC_W'(1);
            beep_n     = ~beep;
          end
        end
      end
      ST_SNOOZED: begin
        if (arm_toggle) begin
          state_n = ST_IDLE;
          left_n  = SNZ_FULL;
        end else if (dismiss) begin
          state_n = ST_ARMED;
          left_n  = SNZ_FULL;
        end else if (tick && now_secs == wake) begin
          state_n    = ST_RINGING;
          ring_cnt_n = '0;
          beep_n     = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ring_cnt    <= '0;
      beep        <= 1'b0;
      wake        <= '0;
      snooze_left <= SNZ_FULL;
      alarm_secs  <= '0;
      set_err     <= 1'b0;
      armed       <= 1'b0;
      ringing     <= 1'b0;
      buzz        <= 1'b0;
    end else begin
      state       <= state_n;
      ring_cnt    <= ring_cnt_n;
      beep        <= beep_n;
      wake        <= wake_n;
      snooze_left <= left_n;
      alarm_secs  <= alarm_n;
      set_err     <= set_bad;
      armed       <= (state_n != ST_IDLE);
      ringing     <= (state_n == ST_RINGING);
      buzz        <= (state_n == ST_RINGING) && beep_n;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed vector bench for alarm_ctrl
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, set_valid, arm_toggle, snooze, dismiss;
  logic [16:0] now_secs, set_secs, alarm_secs;
  logic        armed, ringing, buzz, set_err;
  logic [1:0]  snooze_left;

  typedef struct {
    bit          rst;
    bit          tick;
    logic [16:0] now;
    bit          sv;
    logic [16:0] ss;
    bit          arm;
    bit          snz;
    bit          dis;
    logic [16:0] e_alarm;
    bit          e_armed;
    bit          e_ring;
    bit          e_buzz;
    logic [1:0]  e_left;
    bit          e_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[19];

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .now_secs    (now_secs),
    .set_valid   (set_valid),
    .set_secs    (set_secs),
    .arm_toggle  (arm_toggle),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .alarm_secs  (alarm_secs),
    .armed       (armed),
    .ringing     (ringing),
    .buzz        (buzz),
    .snooze_left (snooze_left),
    .set_err     (set_err)
  );

  function automatic vec_t mk(bit r, bit t, int now, bit sv, int ss, bit a, bit s, bit d,
                              int ea, bit earm, bit er, bit eb, int el, bit ee);
    vec_t v;
    v.rst = r; v.tick = t; v.now = 17'(now); v.sv = sv; v.ss = 17'(ss);
    v.arm = a; v.snz = s; v.dis = d;
    v.e_alarm = 17'(ea); v.e_armed = earm; v.e_ring = er; v.e_buzz = eb;
    v.e_left = 2'(el); v.e_err = ee;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; tick = v.tick; now_secs = v.now; set_valid = v.sv; set_secs = v.ss;
    arm_toggle = v.arm; snooze = v.snz; dismiss = v.dis;
    @(posedge clk);
    #1;
    n_vec++;
    if (alarm_secs !== v.e_alarm || armed !== v.e_armed || ringing !== v.e_ring ||
        buzz !== v.e_buzz || snooze_left !== v.e_left || set_err !== v.e_err) begin
      n_bad++;
      $display("FAIL %s: got alarm=%0d armed=%b ring=%b buzz=%b left=%0d err=%b, want alarm=%0d armed=%b ring=%b buzz=%b left=%0d err=%b",
               name, alarm_secs, armed, ringing, buzz, snooze_left, set_err,
               v.e_alarm, v.e_armed, v.e_ring, v.e_buzz, v.e_left, v.e_err);
    end
    rst = 0; tick = 0; set_valid = 0; arm_toggle = 0; snooze = 0; dismiss = 0;
  endtask

  initial begin
    rst = 1; tick = 0; now_secs = 0; set_valid = 0; set_secs = 0;
    arm_toggle = 0; snooze = 0; dismiss = 0;

    //               rst tk now   sv ss     ar sz ds  alarm arm rng bz lft err
    tbl[0]  = mk(1, 0, 0,     0, 0,     0, 0, 0,  0,     0, 0, 0, 3, 0);
    tbl[1]  = mk(0, 0, 0,     1, 100,   0, 0, 0,  100,   0, 0, 0, 3, 0);
    tbl[2]  = mk(0, 0, 0,     1, 86400, 0, 0, 0,  100,   0, 0, 0, 3, 1);
    tbl[3]  = mk(0, 0, 0,     0, 0,     0, 0, 0,  100,   0, 0, 0, 3, 0);
    tbl[4]  = mk(0, 0, 0,     0, 0,     1, 0, 0,  100,   1, 0, 0, 3, 0);
    tbl[5]  = mk(0, 1, 99,    0, 0,     0, 0, 0,  100,   1, 0, 0, 3, 0);
    tbl[6]  = mk(0, 1, 101,   0, 0,     0, 0, 0,  100,   1, 0, 0, 3, 0);
    tbl[7]  = mk(0, 1, 100,   0, 0,     0, 0, 0,  100,   1, 1, 1, 3, 0);
    tbl[8]  = mk(0, 1, 101,   0, 0,     0, 0, 0,  100,   1, 1, 0, 3, 0);
    tbl[9]  = mk(0, 0, 101,   0, 0,     0, 0, 0,  100,   1, 1, 0, 3, 0);
    tbl[10] = mk(0, 1, 102,   0, 0,     0, 0, 0,  100,   1, 1, 1, 3, 0);
    tbl[11] = mk(0, 0, 102,   1, 200,   0, 0, 0,  100,   1, 1, 1, 3, 0);
    tbl[12] = mk(0, 0, 102,   1, 90000, 0, 0, 0,  100,   1, 1, 1, 3, 1);
    tbl[13] = mk(0, 0, 102,   0, 0,     0, 1, 1,  100,   1, 0, 0, 3, 0);
    tbl[14] = mk(0, 1, 100,   0, 0,     0, 0, 0,  100,   1, 1, 1, 3, 0);
    tbl[15] = mk(1, 0, 100,   0, 0,     0, 0, 0,  0,     0, 0, 0, 3, 0);
    tbl[16] = mk(0, 0, 0,     1, 50,    1, 0, 0,  50,    1, 0, 0, 3, 0);
    tbl[17] = mk(0, 1, 50,    1, 60,    0, 0, 0,  60,    1, 1, 1, 3, 0);
    tbl[18] = mk(0, 0, 50,    0, 0,     1, 0, 0,  60,    0, 0, 0, 3, 0);

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Ring timeout: 59 more ticks keep ringing, the 60th silences.
    apply(mk(1, 0, 0,   0, 0,   0, 0, 0, 0,   0, 0, 0, 3, 0), "to_rst");
    apply(mk(0, 0, 0,   1, 100, 1, 0, 0, 100, 1, 0, 0, 3, 0), "to_set_arm");
    apply(mk(0, 1, 100, 0, 0,   0, 0, 0, 100, 1, 1, 1, 3, 0), "to_ring");
    for (int k = 1; k <= 59; k++) begin
      apply(mk(0, 1, 100 + k, 0, 0, 0, 0, 0, 100, 1, 1, (k % 2) == 0, 3, 0),
            $sformatf("to_tick%0d", k));
    end
    apply(mk(0, 1, 160, 0, 0,   0, 0, 0, 100, 1, 0, 0, 3, 0), "to_silence");

    // Snooze across midnight, exhaust snoozes, then dismiss.
    apply(mk(1, 0, 0,     0, 0,     0, 0, 0, 0,     0, 0, 0, 3, 0), "sn_rst");
    apply(mk(0, 0, 0,     1, 86200, 1, 0, 0, 86200, 1, 0, 0, 3, 0), "sn_set_arm");
    apply(mk(0, 1, 86200, 0, 0,     0, 0, 0, 86200, 1, 1, 1, 3, 0), "sn_ring");
    apply(mk(0, 0, 86200, 0, 0,     0, 1, 0, 86200, 1, 0, 0, 2, 0), "sn_snz1");
    apply(mk(0, 1, 99,    0, 0,     0, 0, 0, 86200, 1, 0, 0, 2, 0), "sn_wait99");
    apply(mk(0, 1, 100,   0, 0,     0, 0, 0, 86200, 1, 1, 1, 2, 0), "sn_wake100");
    apply(mk(0, 0, 100,   0, 0,     0, 1, 0, 86200, 1, 0, 0, 1, 0), "sn_snz2");
    apply(mk(0, 1, 400,   0, 0,     0, 0, 0, 86200, 1, 1, 1, 1, 0), "sn_wake400");
    apply(mk(0, 0, 400,   0, 0,     0, 1, 0, 86200, 1, 0, 0, 0, 0), "sn_snz3");
    apply(mk(0, 1, 700,   0, 0,     0, 0, 0, 86200, 1, 1, 1, 0, 0), "sn_wake700");
    apply(mk(0, 0, 700,   0, 1,     0, 1, 0, 86200, 1, 1, 1, 0, 0), "sn_snz4_ignored");
    apply(mk(0, 0, 700,   0, 0,     0, 0, 1, 86200, 1, 0, 0, 3, 0), "sn_dismiss");

    // Reset while snoozed.
    apply(mk(0, 1, 86200, 0, 0,     0, 0, 0, 86200, 1, 1, 1, 3, 0), "rs_ring");
    apply(mk(0, 0, 86200, 0, 0,     0, 1, 0, 86200, 1, 0, 0, 2, 0), "rs_snz");
    apply(mk(1, 0, 86200, 0, 0,     0, 0, 0, 0,     0, 0, 0, 3, 0), "rs_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
